// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, rate defaults and bit-time helper
package uart_pkg;

   localparam int DEF_BIT_RATE = 9600;
   localparam int DEF_CLK_HZ   = 100000000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_BREAK
   } tx_state_t;

   function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
      return clk_hz / bit_rate;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: reloadable down counter giving a one-cycle tick per bit time
module uart_bit_timer #(
   parameter int CYCLES = 10
) (
   input  logic clk,
   input  logic resetn,
   input  logic i_load,
   output logic o_tick
);

   localparam int W = $clog2(CYCLES + 1);
   localparam logic [W-1:0] RELOAD = W'(CYCLES - 1);

   logic [W-1:0] r_cnt;

   // count down to zero, restarting at the top on a tick or while held in load
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_cnt <= '0;
      else r_cnt <= (i_load || r_cnt == '0) ? RELOAD : r_cnt - W'(1);
   end

   assign o_tick = !i_load && r_cnt == '0;

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter with start/data/stop framing and BREAK generation
module uart_tx
   import uart_pkg::*;
#(
   parameter int BIT_RATE     = DEF_BIT_RATE,
   parameter int CLK_HZ       = DEF_CLK_HZ,
   parameter int PAYLOAD_BITS = 8,
   parameter int STOP_BITS    = 1
) (
   input  logic                    clk,
   input  logic                    resetn,
   output logic                    uart_txd,
   output logic                    tx_busy,
   input  logic                    tx_en,
   input  logic [PAYLOAD_BITS-1:0] tx_data,
   input  logic                    tx_break
);

   localparam int CPB = cycles_per_bit(CLK_HZ, BIT_RATE);
   localparam logic [3:0] LAST_DATA = 4'(PAYLOAD_BITS - 1);
   localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
   localparam logic [3:0] LAST_BRK  = 4'(PAYLOAD_BITS + STOP_BITS);

   tx_state_t               r_state, w_state_nxt;
   logic [3:0]              r_idx, w_idx_nxt;
   logic [PAYLOAD_BITS-1:0] r_data;
   logic [7:0]              w_data8;
   logic                    r_txd, r_busy, w_txd_nxt, w_tick, w_load;

   assign w_load  = r_state == ST_IDLE;
   assign w_data8 = 8'(r_data);

   uart_bit_timer #(.CYCLES(CPB)) u_timer (
      .clk    (clk),
      .resetn (resetn),
      .i_load (w_load),
      .o_tick (w_tick)
   );

   // next state, bit/stop/break index and the line level the next state drives
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      case (r_state)
         ST_IDLE:  w_state_nxt = tx_break ? ST_BREAK : (tx_en ? ST_START : ST_IDLE);
         ST_START: w_state_nxt = w_tick ? ST_DATA : ST_START;
         ST_DATA:
            if (w_tick) begin
               if (r_idx == LAST_DATA) w_state_nxt = ST_STOP;
               else w_idx_nxt = r_idx + 4'd1;
            end
         ST_STOP:
            if (w_tick) begin
               if (r_idx == LAST_STOP) w_state_nxt = ST_IDLE;
               else w_idx_nxt = r_idx + 4'd1;
            end
         ST_BREAK:
            if (w_tick) begin
               if (r_idx != LAST_BRK) w_idx_nxt = r_idx + 4'd1;
               else if (!tx_break) w_state_nxt = ST_STOP;
            end
         default: w_state_nxt = ST_IDLE;
      endcase
      if (w_state_nxt != r_state) w_idx_nxt = '0;
      w_txd_nxt = (w_state_nxt == ST_DATA) ? w_data8[w_idx_nxt[2:0]] :
                  !(w_state_nxt == ST_START || w_state_nxt == ST_BREAK);
   end

   // state, index, captured byte and registered line outputs
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_data  <= '0;
         r_txd   <= 1'b1;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_txd   <= w_txd_nxt;
         r_busy  <= w_state_nxt != ST_IDLE;
         if (r_state == ST_IDLE && tx_en && !tx_break) r_data <= tx_data;
      end
   end

   assign uart_txd = r_txd;
   assign tx_busy  = r_busy;

endmodule
